// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg -- shared types and constants for the tone-EQ biquad sequencer.
//   tap_e          : coefficient/tap select order used on o_tap (a0,a1,a2,b1,b2)
//   seq_state_e    : sequencer FSM states
//   biquad_hist_t  : per-stage Direct-Form-I history (x[n-1], x[n-2], y[n-1], y[n-2])
//   COEF_FRAC/ONE  : Q4.28 coefficient format
// Build option: EQ_SEQ_SAT_EN (see eq_mac) selects saturating vs wrapping narrow.
// ---------------------------------------------------------------------------
package eq_pkg;

    localparam int               HIST_W    = 16;
    localparam int               COEF_FRAC = 28;
    localparam logic signed [31:0] COEF_ONE = 32'sh1000_0000;

    typedef enum logic [2:0] {
        TAP_A0 = 3'd0,
        TAP_A1 = 3'd1,
        TAP_A2 = 3'd2,
        TAP_B1 = 3'd3,
        TAP_B2 = 3'd4
    } tap_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    // Histories always hold the narrowed sample, never the raw accumulator.
    typedef struct packed {
        logic signed [HIST_W-1:0] x1;
        logic signed [HIST_W-1:0] x2;
        logic signed [HIST_W-1:0] y1;
        logic signed [HIST_W-1:0] y2;
    } biquad_hist_t;

endpackage

// File: rtl/eq_mac.sv
// ---------------------------------------------------------------------------
// eq_mac -- the single shared multiply-accumulate unit of the biquad cascade.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : accumulate this cycle
//   clear      : start a new sum (tap 0) instead of adding to the old one
//   subtract   : feedback taps (b1, b2) subtract their product
//   sample     : signed history/input sample for the current tap
//   coef       : signed Q4.28 coefficient for the current tap
//   y          : accumulator rounded half-up and narrowed to DATA_W
// Build option: EQ_SEQ_SAT_EN defined -> y saturates to the DATA_W range;
//               undefined -> y is the two's-complement wrap of the rounded sum.
// ---------------------------------------------------------------------------
module eq_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 32,
    parameter int COEF_FRAC = 28,
    parameter int ACC_W     = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clear,
    input  logic              subtract,
    input  logic [DATA_W-1:0] sample,
    input  logic [COEF_W-1:0] coef,
    output logic [DATA_W-1:0] y
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] ROUND_HALF = ACC_W'(1'b1) << (COEF_FRAC - 1);

    logic signed [PROD_W-1:0] prod_s;
    logic signed [ACC_W-1:0]  prod_ext_s;
    logic signed [ACC_W-1:0]  base_s;
    logic signed [ACC_W-1:0]  acc_next_s;
    logic signed [ACC_W-1:0]  acc_r;

    // Product, sign-extended into the accumulator, then added or subtracted
    always_comb begin
        prod_s     = PROD_W'($signed(sample)) * PROD_W'($signed(coef));
        prod_ext_s = ACC_W'(prod_s);
        base_s     = clear ? '0 : acc_r;
        if (subtract) begin
            acc_next_s = base_s - prod_ext_s;
        end else begin
            acc_next_s = base_s + prod_ext_s;
        end
    end

    // Accumulator register; holds its value outside tap cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= acc_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

`ifdef EQ_SEQ_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

    logic signed [ACC_W-1:0] shifted_s;

    // Round half up, then clamp into the DATA_W signed range
    always_comb begin
        shifted_s = (acc_r + ROUND_HALF) >>> COEF_FRAC;
        if (shifted_s > Y_MAX) begin
            y = DATA_W'(Y_MAX);
        end else if (shifted_s < Y_MIN) begin
            y = DATA_W'(Y_MIN);
        end else begin
            y = DATA_W'(shifted_s);
        end
    end
`else
    // Round half up, then keep the low DATA_W bits (two's-complement wrap)
    always_comb begin
        y = DATA_W'((acc_r + ROUND_HALF) >>> COEF_FRAC);
    end
`endif

endmodule

// File: rtl/eq_biquad_sequencer.sv
// ---------------------------------------------------------------------------
// eq_biquad_sequencer -- time-multiplexed controller for a cascade of
// NUM_STAGES Direct-Form-I biquads (stage 0 bass, stage 1 treble) sharing one
// eq_mac. Per accepted sample: 5 tap cycles + 1 writeback cycle per stage,
// then the result is presented with a one-cycle o_valid.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_valid      : new-sample strobe;  i_enable : 1 filter, 0 bypass
//   i_data       : signed input sample
//   o_stage/o_tap: coefficient LUT select (0 outside tap cycles)
//   i_coef       : coefficient returned combinationally for o_stage/o_tap
//   o_busy       : sample in flight;   o_overrun : sample dropped while busy
//   o_data       : result, held until the next o_valid
// Build option: EQ_SEQ_SAT_EN (saturating narrow, implemented in eq_mac).
// ---------------------------------------------------------------------------
module eq_biquad_sequencer
    import eq_pkg::*;
#(
    parameter int NUM_STAGES = 2,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 32,
    parameter int COEF_FRAC  = eq_pkg::COEF_FRAC,
    parameter int ACC_W      = 56,
    localparam int STAGE_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_enable,
    input  logic [DATA_W-1:0]  i_data,
    output logic [STAGE_W-1:0] o_stage,
    output logic [2:0]         o_tap,
    input  logic [COEF_W-1:0]  i_coef,
    output logic               o_busy,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_valid,
    output logic               o_overrun
);

    seq_state_e          state_r, state_n;
    tap_e                tap_r, tap_n;
    logic [STAGE_W-1:0]  stage_r, stage_n;
    logic [DATA_W-1:0]   x_in_r;           // current stage input: sample, then previous stage's y
    biquad_hist_t        hist_r [NUM_STAGES];

    logic                accept_s, bypass_s, overrun_s, wb_s, done_s;
    logic                mac_en_s, mac_clear_s, mac_sub_s;
    logic [DATA_W-1:0]   mac_sample_s;
    logic [DATA_W-1:0]   mac_y_s;

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_n     = state_r;
        tap_n       = tap_r;
        stage_n     = stage_r;
        accept_s    = 1'b0;
        bypass_s    = 1'b0;
        overrun_s   = 1'b0;
        wb_s        = 1'b0;
        done_s      = 1'b0;
        mac_en_s    = 1'b0;
        mac_clear_s = 1'b0;
        mac_sub_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                // DONE also accepts, giving back-to-back throughput
                if (i_valid && i_enable) begin
                    accept_s = 1'b1;
                    state_n  = MAC;
                    tap_n    = TAP_A0;
                    stage_n  = '0;
                end else if (i_valid) begin
                    bypass_s = 1'b1;
                    state_n  = IDLE;
                end else begin
                    state_n  = IDLE;
                end
            end
            MAC: begin
                overrun_s   = i_valid;
                mac_en_s    = 1'b1;
                mac_clear_s = (tap_r == TAP_A0);
                mac_sub_s   = (tap_r == TAP_B1) || (tap_r == TAP_B2);
                if (tap_r == TAP_B2) begin
                    state_n = WB;
                    tap_n   = TAP_A0;
                end else begin
                    tap_n   = tap_e'(tap_r + 3'd1);
                end
            end
            WB: begin
                overrun_s = i_valid;
                wb_s      = 1'b1;
                if (stage_r == STAGE_W'(NUM_STAGES - 1)) begin
                    done_s  = 1'b1;
                    state_n = DONE;
                    stage_n = '0;
                end else begin
                    state_n = MAC;
                    stage_n = stage_r + STAGE_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // MAC operand select: which history word feeds the current tap
    always_comb begin
        case (tap_r)
            TAP_A0:  mac_sample_s = x_in_r;
            TAP_A1:  mac_sample_s = hist_r[stage_r].x1;
            TAP_A2:  mac_sample_s = hist_r[stage_r].x2;
            TAP_B1:  mac_sample_s = hist_r[stage_r].y1;
            TAP_B2:  mac_sample_s = hist_r[stage_r].y2;
            default: mac_sample_s = '0;
        endcase
    end

    eq_mac #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .COEF_FRAC(COEF_FRAC),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk     (i_clk),
        .rst     (i_rst),
        .en      (mac_en_s),
        .clear   (mac_clear_s),
        .subtract(mac_sub_s),
        .sample  (mac_sample_s),
        .coef    (i_coef),
        .y       (mac_y_s)
    );

    // FSM and tap/stage counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
            tap_r   <= TAP_A0;
            stage_r <= '0;
        end else begin
            state_r <= state_n;
            tap_r   <= tap_n;
            stage_r <= stage_n;
        end
    end

    // Stage input latch: the accepted sample, then each stage's output
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            x_in_r <= '0;
        end else if (accept_s) begin
            x_in_r <= i_data;
        end else if (wb_s) begin
            x_in_r <= mac_y_s;
        end else begin
            x_in_r <= x_in_r;
        end
    end

    // Biquad histories: shift on writeback, cleared by bypass
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                hist_r[i] <= '0;
            end
        end else if (bypass_s) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                hist_r[i] <= '0;
            end
        end else if (wb_s) begin
            hist_r[stage_r].x2 <= hist_r[stage_r].x1;
            hist_r[stage_r].x1 <= x_in_r;
            hist_r[stage_r].y2 <= hist_r[stage_r].y1;
            hist_r[stage_r].y1 <= mac_y_s;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                hist_r[i] <= hist_r[i];
            end
        end
    end

    // Registered outputs; LUT selects are registered from the next-state values
    // so they line up with the tap being executed in the following cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
            o_busy    <= 1'b0;
            o_stage   <= '0;
            o_tap     <= 3'd0;
            o_data    <= '0;
        end else begin
            o_valid   <= done_s | bypass_s;
            o_overrun <= overrun_s;
            o_busy    <= (state_n == MAC) || (state_n == WB);
            o_stage   <= (state_n == MAC) ? stage_n : '0;
            o_tap     <= (state_n == MAC) ? 3'(tap_n) : 3'd0;
            if (done_s) begin
                o_data <= mac_y_s;
            end else if (bypass_s) begin
                o_data <= i_data;
            end else begin
                o_data <= o_data;
            end
        end
    end

endmodule

// File: tb/tb_eq_biquad_sequencer.sv
// ---------------------------------------------------------------------------
// tb_eq_biquad_sequencer -- scoreboard bench for eq_biquad_sequencer.
// The driver computes each expected result from a plain-arithmetic biquad
// model and queues it with its due cycle; an independent monitor pops and
// compares whenever o_valid is seen, and checks busy/overrun/select timing.
// ---------------------------------------------------------------------------
module tb_eq_biquad_sequencer;
    import eq_pkg::*;

    localparam int NS      = 2;
    localparam int NO_WANT = 100000;
    localparam int LAT     = 6 * NS + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_enable;
    logic [15:0] i_data;
    logic [0:0]  o_stage;
    logic [2:0]  o_tap;
    logic [31:0] i_coef;
    logic        o_busy, o_valid, o_overrun;
    logic [15:0] o_data;

    eq_biquad_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_enable(i_enable),
        .i_data(i_data), .o_stage(o_stage), .o_tap(o_tap), .i_coef(i_coef),
        .o_busy(o_busy), .o_data(o_data), .o_valid(o_valid), .o_overrun(o_overrun)
    );

    always #5 clk = ~clk;

    // external coefficient LUT
    logic signed [31:0] coef_tab [NS][5];
    always_comb i_coef = (o_tap < 3'd5) ? coef_tab[o_stage][o_tap] : 32'd0;

    typedef struct { int cyc; int data; } exp_t;
    exp_t q[$];

    int cyc = 0;
    int n_vec = 0, n_err = 0;
    int last_k = 0;
    bit has_acc = 1'b0;
    int exp_ovr = -1;
    int mx1[NS], mx2[NS], my1[NS], my2[NS];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, want);
        end
    endtask

    function automatic int narrow(input longint v);
        logic [63:0] t;
`ifdef EQ_SEQ_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
`else
        t = v;
        return int'($signed(t[15:0]));
`endif
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < NS; s++) begin
            mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
        end
    endfunction

    // y = round(a0*x + a1*x1 + a2*x2 - b1*y1 - b2*y2), stage by stage
    function automatic int model_filter(input int x_in);
        int x, y;
        longint acc, r;
        x = x_in;
        for (int s = 0; s < NS; s++) begin
            acc = longint'(coef_tab[s][0]) * x + longint'(coef_tab[s][1]) * mx1[s]
                + longint'(coef_tab[s][2]) * mx2[s] - longint'(coef_tab[s][3]) * my1[s]
                - longint'(coef_tab[s][4]) * my2[s];
            r = (acc + 64'sd134217728) >>> 28;
            y = narrow(r);
            mx2[s] = mx1[s]; mx1[s] = x; my2[s] = my1[s]; my1[s] = y;
            x = y;
        end
        return x;
    endfunction

    task automatic set_coef(input int s, input int a0, input int a1, input int a2, input int b1, input int b2);
        coef_tab[s][0] = a0; coef_tab[s][1] = a1; coef_tab[s][2] = a2;
        coef_tab[s][3] = b1; coef_tab[s][4] = b2;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one strobe at the current negedge; queue what must come out
    task automatic send(input int x, input bit en, input int want = NO_WANT);
        int c, m;
        exp_t e;
        c = cyc;
        i_valid = 1'b1; i_enable = en; i_data = 16'(x);
        if (has_acc && (c - last_k) >= 1 && (c - last_k) < LAT) begin
            exp_ovr = c + 1;
        end else if (en) begin
            m = model_filter(x);
            e.cyc = c + LAT; e.data = (want == NO_WANT) ? m : want;
            q.push_back(e);
            last_k = c; has_acc = 1'b1;
        end else begin
            model_clear();
            e.cyc = c + 1; e.data = (want == NO_WANT) ? x : want;
            q.push_back(e);
        end
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Monitor: timing of busy/selects/overrun every cycle, results on o_valid
    always @(posedge clk) begin : mon
        int rel, t;
        logic eb;
        logic [0:0] es;
        logic [2:0] et;
        exp_t e;
        #1;
        rel = has_acc ? (cyc - last_k) : -1;
        eb = (rel >= 1) && (rel < LAT);
        es = 1'b0; et = 3'd0;
        if (eb) begin
            t = (rel - 1) % 6;
            if (t < 5) begin
                es = 1'((rel - 1) / 6);
                et = 3'(t);
            end
        end
        chk("busy", o_busy, eb);
        chk("stage", o_stage, es);
        chk("tap", o_tap, et);
        chk("overrun", o_overrun, (cyc == exp_ovr));
        if (o_valid) begin
            if (q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_valid @cyc %0d: got o_data %0d expected no output", cyc, $signed(o_data));
            end else begin
                e = q.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("o_data", $signed(o_data), e.data);
            end
        end else if (q.size() != 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_vec++; n_err++;
            $display("FAIL missing_valid @cyc %0d: got no output expected %0d at cycle %0d", cyc, e.data, e.cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, g;
        rst = 1'b1; i_valid = 1'b0; i_enable = 1'b0; i_data = 16'd0;
        for (int s = 0; s < NS; s++) set_coef(s, COEF_ONE, 0, 0, 0, 0);
        model_clear();
        idle(3);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_data", o_data, 16'd0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_overrun", o_overrun, 1'b0);
        chk("rst_stage", o_stage, 1'b0);
        chk("rst_tap", o_tap, 3'd0);
        rst = 1'b0;
        idle(2);

        // identity cascade
        send(1000, 1'b1, 1000);
        idle(14);

        // bypass (also clears histories), then half-sum FIR on stage 0
        send(-1234, 1'b0, -1234);
        set_coef(0, COEF_ONE / 2, COEF_ONE / 2, 0, 0, 0);
        send(1000, 1'b1, 500); idle(12);
        send(0, 1'b1, 500);    idle(12);
        send(0, 1'b1, 0);      idle(14);

        // gain of 2 on full-scale input: saturate or wrap
        set_coef(0, 2 * COEF_ONE, 0, 0, 0, 0);
`ifdef EQ_SEQ_SAT_EN
        send(32767, 1'b1, 32767);
`else
        send(32767, 1'b1, -2);
`endif
        idle(14);

        // second strobe 4 cycles after accept is dropped
        set_coef(0, COEF_ONE, 0, 0, 0, 0);
        send(1234, 1'b1, 1234);
        idle(3);
        send(555, 1'b1);
        idle(12);

        // bypass then recursive coefficients: histories must start from 0
        for (int s = 0; s < NS; s++) set_coef(s, COEF_ONE, COEF_ONE / 4, COEF_ONE / 8, -COEF_ONE / 2, COEF_ONE / 4);
        send(-1234, 1'b0, -1234);
        send(2000, 1'b1, 2000);
        idle(14);

        // reset in cycle 7 aborts the sample and clears histories
        send(3000, 1'b1);
        idle(6);
        rst = 1'b1;
        q.delete(); has_acc = 1'b0; model_clear();
        idle(2);
        chk("abort_valid", o_valid, 1'b0);
        chk("abort_data", o_data, 16'd0);
        chk("abort_busy", o_busy, 1'b0);
        rst = 1'b0;
        idle(2);
        send(1500, 1'b1, 1500);
        idle(14);

        // randomized traffic
        for (int i = 0; i < 80; i++) begin
            if (i % 10 == 0) begin
                for (int s = 0; s < NS; s++)
                    set_coef(s, int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000,
                                int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000,
                                int'($urandom_range(0, 32'h2000_0000)) - 32'sh1000_0000,
                                int'($urandom_range(0, 32'h2000_0000)) - 32'sh1000_0000,
                                int'($urandom_range(0, 32'h1000_0000)) - 32'sh0800_0000);
            end
            kind = int'($urandom_range(0, 9));
            if (kind == 0) begin
                send(int'($urandom_range(0, 65535)) - 32768, 1'b0);
                idle(int'($urandom_range(0, 2)));
            end else if (kind == 1) begin
                send(int'($urandom_range(0, 65535)) - 32768, 1'b1);
                g = int'($urandom_range(0, 10));
                idle(g);
                send(int'($urandom_range(0, 65535)) - 32768, 1'b1);
                idle(11 - g);
            end else begin
                send(int'($urandom_range(0, 65535)) - 32768, 1'b1);
                idle(int'($urandom_range(12, 15)));
            end
        end

        idle(20);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
